// File: rtl/meas_discriminator.sv
// ---------------------------------------------------------------------------
// meas_discriminator
// Upstream stage of the function-processor measurement path. Accepts a
// time-multiplexed stream of accumulated readout results (I, Q, channel),
// projects each onto a per-channel axis (I*coef_i + Q*coef_q) and compares
// the projection against a per-channel threshold to form a state bit.
//
// Ports
//   clk         clock
//   reset_n     synchronous reset, active low
//   acc_valid   acc_* valid this cycle (at most one result per cycle)
//   acc_chan    channel of the result
//   acc_i/q     accumulated I/Q, signed ACC_W
//   cfg_we      config write strobe
//   cfg_chan    config target channel
//   cfg_sel     0=coef_i 1=coef_q 2=threshold 3=reserved (ignored)
//   cfg_data    write data, sign-truncated per field
//   meas_clear  per-channel valid clear (sticky build only)
//   meas        latest state bit per channel
//   meas_valid  per-channel result-available flag
//   chan_err    1-cycle pulse when a result with acc_chan >= N_MEAS is dropped
//
// Build option
//   MEAS_DISC_STICKY_VALID_EN: meas_valid[c] is held until meas_clear[c];
//   otherwise meas_valid[c] is a single-cycle pulse per result.
//
// Latency: acc_valid sampled at edge T -> meas/meas_valid updated at T+3.
// ---------------------------------------------------------------------------
module meas_discriminator #(
  parameter int N_MEAS = 5,
  parameter int ACC_W  = 16,
  parameter int COEF_W = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             acc_valid,
  input  logic [$clog2(N_MEAS)-1:0]        acc_chan,
  input  logic signed [ACC_W-1:0]          acc_i,
  input  logic signed [ACC_W-1:0]          acc_q,
  input  logic                             cfg_we,
  input  logic [$clog2(N_MEAS)-1:0]        cfg_chan,
  input  logic [1:0]                       cfg_sel,
  input  logic [ACC_W+COEF_W:0]            cfg_data,
  input  logic [N_MEAS-1:0]                meas_clear,
  output logic [N_MEAS-1:0]                meas,
  output logic [N_MEAS-1:0]                meas_valid,
  output logic                             chan_err
);

  localparam int CW = $clog2(N_MEAS);
  localparam int P  = ACC_W + COEF_W;
  localparam int S  = P + 1;
  localparam logic [CW:0] NM = (CW+1)'(N_MEAS);

  // Sign-extend both products by one bit so their sum cannot overflow.
  function automatic logic signed [S-1:0] add_ext(input logic signed [P-1:0] a,
                                                  input logic signed [P-1:0] b);
    return $signed({a[P-1], a}) + $signed({b[P-1], b});
  endfunction

  // Per-channel configuration
  logic signed [COEF_W-1:0] r_coef_i [N_MEAS];
  logic signed [COEF_W-1:0] r_coef_q [N_MEAS];
  logic signed [S-1:0]      r_thr    [N_MEAS];

  logic          w_acc_ok, w_cfg_ok;
  logic [CW-1:0] w_rd_idx, w_wr_idx;

  assign w_acc_ok = ({1'b0, acc_chan} < NM);
  assign w_cfg_ok = ({1'b0, cfg_chan} < NM);
  // Clamp indices so array accesses stay in range for dropped channels.
  assign w_rd_idx = w_acc_ok ? acc_chan : '0;
  assign w_wr_idx = w_cfg_ok ? cfg_chan : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < N_MEAS; c++) begin
        r_coef_i[c] <= COEF_W'(1);
        r_coef_q[c] <= '0;
        r_thr[c]    <= '0;
      end
    end else if (cfg_we && w_cfg_ok) begin
      case (cfg_sel)
        2'd0:    r_coef_i[w_wr_idx] <= cfg_data[COEF_W-1:0];
        2'd1:    r_coef_q[w_wr_idx] <= cfg_data[COEF_W-1:0];
        2'd2:    r_thr[w_wr_idx]    <= cfg_data;
        default: ;
      endcase
    end
  end

  // Pipeline control (valids, error flag)
  logic r_vld_p1, r_vld_p2, r_vld_p3, r_err_p1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
      r_err_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= acc_valid && w_acc_ok;
      r_err_p1 <= acc_valid && !w_acc_ok;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
    end
  end

  // Pipeline data
  logic [CW-1:0]            r_chan_p1, r_chan_p2, r_chan_p3;
  logic signed [ACC_W-1:0]  r_i_p1, r_q_p1;
  logic signed [COEF_W-1:0] r_ci_p1, r_cq_p1;
  logic signed [S-1:0]      r_thr_p1, r_thr_p2, r_thr_p3;
  logic signed [P-1:0]      r_pi_p2, r_pq_p2;
  logic signed [S-1:0]      r_sum_p3;
  logic signed [P-1:0]      w_i_ext, w_q_ext, w_ci_ext, w_cq_ext;

  assign w_i_ext  = $signed({{COEF_W{r_i_p1[ACC_W-1]}}, r_i_p1});
  assign w_q_ext  = $signed({{COEF_W{r_q_p1[ACC_W-1]}}, r_q_p1});
  assign w_ci_ext = $signed({{ACC_W{r_ci_p1[COEF_W-1]}}, r_ci_p1});
  assign w_cq_ext = $signed({{ACC_W{r_cq_p1[COEF_W-1]}}, r_cq_p1});

  always_ff @(posedge clk) begin
    // S1: capture sample and the channel's configuration
    r_chan_p1 <= w_rd_idx;
    r_i_p1    <= acc_i;
    r_q_p1    <= acc_q;
    r_ci_p1   <= r_coef_i[w_rd_idx];
    r_cq_p1   <= r_coef_q[w_rd_idx];
    r_thr_p1  <= r_thr[w_rd_idx];
    // S2: full-width signed products
    r_chan_p2 <= r_chan_p1;
    r_pi_p2   <= w_i_ext * w_ci_ext;
    r_pq_p2   <= w_q_ext * w_cq_ext;
    r_thr_p2  <= r_thr_p1;
    // S3: projection sum
    r_chan_p3 <= r_chan_p2;
    r_sum_p3  <= add_ext(r_pi_p2, r_pq_p2);
    r_thr_p3  <= r_thr_p2;
  end

  // Output stage: strict signed compare, per-channel update
  logic                w_bit;
  logic [N_MEAS-1:0]   w_set;
  logic [N_MEAS-1:0]   r_meas, r_meas_valid;
  logic                r_chan_err;

  assign w_bit = (r_sum_p3 > r_thr_p3);

  always_comb begin
    w_set = '0;
    for (int c = 0; c < N_MEAS; c++)
      w_set[c] = r_vld_p3 && (r_chan_p3 == CW'(c));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meas       <= '0;
      r_meas_valid <= '0;
      r_chan_err   <= 1'b0;
    end else begin
      r_chan_err <= r_err_p1;
      for (int c = 0; c < N_MEAS; c++)
        if (w_set[c]) r_meas[c] <= w_bit;
`ifdef MEAS_DISC_STICKY_VALID_EN
      // A new result outranks a clear arriving in the same cycle.
      r_meas_valid <= (r_meas_valid & ~meas_clear) | w_set;
`else
      r_meas_valid <= w_set;
`endif
    end
  end

`ifndef MEAS_DISC_STICKY_VALID_EN
  logic w_unused_clear;
  assign w_unused_clear = ^meas_clear;
`endif

  assign meas       = r_meas;
  assign meas_valid = r_meas_valid;
  assign chan_err   = r_chan_err;

endmodule

// File: tb/tb_meas_discriminator.sv
module tb_meas_discriminator;

  localparam int N_MEAS = 5;
  localparam int ACC_W  = 16;
  localparam int COEF_W = 16;
  localparam int CW     = $clog2(N_MEAS);
  localparam int DW     = ACC_W + COEF_W + 1;
`ifdef MEAS_DISC_STICKY_VALID_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     acc_valid;
  logic [CW-1:0]            acc_chan;
  logic signed [ACC_W-1:0]  acc_i, acc_q;
  logic                     cfg_we;
  logic [CW-1:0]            cfg_chan;
  logic [1:0]               cfg_sel;
  logic [DW-1:0]            cfg_data;
  logic [N_MEAS-1:0]        meas_clear;
  logic [N_MEAS-1:0]        meas, meas_valid;
  logic                     chan_err;

  int n_checks = 0;
  int n_errors = 0;

  meas_discriminator #(.N_MEAS(N_MEAS), .ACC_W(ACC_W), .COEF_W(COEF_W)) dut (
    .clk(clk), .reset_n(reset_n), .acc_valid(acc_valid), .acc_chan(acc_chan),
    .acc_i(acc_i), .acc_q(acc_q), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .meas_clear(meas_clear),
    .meas(meas), .meas_valid(meas_valid), .chan_err(chan_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards are captured at the following edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int sel, input logic signed [DW-1:0] d);
    cfg_we = 1'b1; cfg_chan = CW'(ch); cfg_sel = 2'(sel); cfg_data = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic clear_all();
    meas_clear = '1;
    cyc();
    meas_clear = '0;
  endtask

  // Issue one sample at edge T and check outputs after T+3 and T+4.
  task automatic run_one(input string tag, input int ch, input int i, input int q,
                         input logic [N_MEAS-1:0] exp_meas, input logic [N_MEAS-1:0] onehot);
    acc_valid = 1'b1; acc_chan = CW'(ch); acc_i = ACC_W'(i); acc_q = ACC_W'(q);
    cyc();
    acc_valid = 1'b0;
    cyc();
    check({tag, "_err"}, 32'(chan_err), 32'd0);
    cyc();
    check({tag, "_vld_early"}, 32'(meas_valid), 32'd0);
    cyc();
    check({tag, "_meas"}, 32'(meas), 32'(exp_meas));
    check({tag, "_vld"}, 32'(meas_valid), 32'(onehot));
    cyc();
    check({tag, "_vld_next"}, 32'(meas_valid), STICKY ? 32'(onehot) : 32'd0);
    clear_all();
  endtask

  initial begin
    reset_n = 1'b0; acc_valid = 1'b0; acc_chan = '0; acc_i = '0; acc_q = '0;
    cfg_we = 1'b0; cfg_chan = '0; cfg_sel = '0; cfg_data = '0; meas_clear = '0;
    cyc(); cyc();
    check("rst_meas", 32'(meas), 32'd0);
    check("rst_vld", 32'(meas_valid), 32'd0);
    check("rst_err", 32'(chan_err), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Defaults: state = I > 0
    run_one("t1", 2, 200, 0, 5'b00100, 5'b00100);

    // Strict threshold compare on ch1
    cfg(1, 2, 100);
    run_one("t2_eq", 1, 100, 0, 5'b00100, 5'b00010);
    run_one("t2_gt", 1, 101, 0, 5'b00110, 5'b00010);

    // Signed path: ch0 projects -Q against -60
    cfg(0, 0, 0);
    cfg(0, 1, -1);
    cfg(0, 2, -60);
    run_one("t3_q50", 0, 0, 50, 5'b00111, 5'b00001);
    run_one("t3_q70", 0, 0, 70, 5'b00110, 5'b00001);
    cfg(0, 3, 5);            // reserved select: no effect
    cfg(5, 2, 1000);         // out-of-range channel: no effect

    // Back-to-back ch0, ch1, ch0; coef_q(ch0) -> +1 written alongside the first sample
    acc_valid = 1'b1; acc_chan = 0; acc_i = 0; acc_q = 100;
    cfg_we = 1'b1; cfg_chan = 0; cfg_sel = 2'd1; cfg_data = 1;
    cyc();
    cfg_we = 1'b0; acc_chan = 1; acc_i = 50; acc_q = 0;
    cyc();
    acc_chan = 0; acc_i = 0; acc_q = 100;
    cyc();
    acc_valid = 1'b0;
    cyc();
    check("t4_a_meas", 32'(meas), 32'b00110);
    check("t4_a_vld", 32'(meas_valid), 32'b00001);
    cyc();
    check("t4_b_meas", 32'(meas), 32'b00100);
    check("t4_b_vld", 32'(meas_valid), STICKY ? 32'b00011 : 32'b00010);
    cyc();
    check("t4_c_meas", 32'(meas), 32'b00101);
    check("t4_c_vld", 32'(meas_valid), STICKY ? 32'b00011 : 32'b00001);
    clear_all();

    // Out-of-range channel is dropped with a single chan_err pulse
    acc_valid = 1'b1; acc_chan = 3'd7; acc_i = 500; acc_q = 0;
    cyc();
    acc_valid = 1'b0;
    check("t5_err_T", 32'(chan_err), 32'd0);
    cyc();
    check("t5_err_T1", 32'(chan_err), 32'd1);
    cyc();
    check("t5_err_T2", 32'(chan_err), 32'd0);
    cyc();
    check("t5_meas", 32'(meas), 32'b00101);
    check("t5_vld", 32'(meas_valid), 32'd0);

    // Reset while a sample is in flight: nothing emerges, config back to defaults
    acc_valid = 1'b1; acc_chan = 3; acc_i = 200; acc_q = 0;
    cyc();
    acc_valid = 1'b0; reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t5_rst_vld", 32'(meas_valid), 32'd0);
      cyc();
    end
    check("t5_rst_meas", 32'(meas), 32'd0);
    run_one("t5_thr_dflt", 1, 100, 0, 5'b00010, 5'b00010);

    // Valid hold / pulse behaviour
    acc_valid = 1'b1; acc_chan = 4; acc_i = 200; acc_q = 0;
    cyc();
    acc_valid = 1'b0;
    cyc(); cyc(); cyc();
    check("t6_meas", 32'(meas), 32'b10010);
    check("t6_vld", 32'(meas_valid), 32'b10000);
    for (int k = 0; k < 20; k++) begin
      cyc();
      check("t6_hold", 32'(meas_valid), STICKY ? 32'b10000 : 32'd0);
    end
    acc_valid = 1'b1; acc_chan = 4; acc_i = -5; acc_q = 0;
    cyc();
    acc_valid = 1'b0;
    cyc(); cyc();
    meas_clear = 5'b10000;
    cyc();
    meas_clear = '0;
    check("t6_clr_new_vld", 32'(meas_valid), 32'b10000);
    check("t6_clr_new_meas", 32'(meas), 32'b00010);
    cyc();
    check("t6_after_vld", 32'(meas_valid), STICKY ? 32'b10000 : 32'd0);
    meas_clear = 5'b10000;
    cyc();
    meas_clear = '0;
    check("t6_cleared", 32'(meas_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
